// File: rtl/uart_pkg.sv
// Shared definitions for the board UART: receiver state encoding, bit timing helper, frame width.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is always presented on rd_data.
// A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) with byte FIFO for the CPU MMIO handshake.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 10_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       r_enable,
    output logic       r_ready,
    output logic [7:0] r_data_out,
    output logic       r_overflow,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned TW   = $clog2(CPB);
    localparam int unsigned BW   = $clog2(DATA_BITS);

    uart_state_t             state;
    uart_state_t             state_nx;
    logic [1:0]              sync;
    logic                    rx_s;
    logic [TW-1:0]           tick;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_BITS-1:0]    shift;
    logic                    half_done;
    logic                    bit_done;
    logic                    last_bit;
    logic                    tick_clr;
    logic                    shift_en;
    logic                    push;
    logic                    frame_hit;
    logic                    par_bad;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    drop;
`ifdef UART_RX_PARITY_EN
    logic                    par_hit;
`endif

    assign rx_s      = sync[1];
    assign half_done = (tick == TW'(HALF - 1));
    assign bit_done  = (tick == TW'(CPB - 1));
    assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!rx_s) state_nx = START;
            START:     if (half_done) state_nx = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_done && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
            PARITY:    if (bit_done) state_nx = STOP;
            STOP:      if (bit_done) state_nx = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // The tick counter restarts on every sample point and whenever the FSM is not timing a bit.
    always_comb begin
        tick_clr  = 1'b1;
        shift_en  = 1'b0;
        push      = 1'b0;
        frame_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_hit   = 1'b0;
`endif
        case (state)
            START:  tick_clr = half_done;
            DATA: begin
                tick_clr = bit_done;
                shift_en = bit_done;
            end
            PARITY: begin
                tick_clr = bit_done;
`ifdef UART_RX_PARITY_EN
                par_hit  = bit_done && ((^shift) ^ rx_s);
`endif
            end
            STOP: begin
                tick_clr  = bit_done;
                push      = bit_done && rx_s && !par_bad;
                frame_hit = bit_done && !rx_s;
            end
            default: tick_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            tick      <= tick_clr ? '0 : tick + TW'(1);
            frame_err <= frame_hit;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (shift_en) begin
                shift <= {rx_s, shift[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_hit;
            if (state == IDLE) begin
                par_bad <= 1'b0;
            end else if (par_hit) begin
                par_bad <= 1'b1;
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (shift),
        .rd_en   (r_enable),
        .rd_data (r_data_out),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign r_ready = !fifo_empty;
    assign drop    = push && fifo_full && !(r_enable && !fifo_empty);

    // A drop in the same cycle as a pop keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (drop) begin
            r_overflow <= 1'b1;
        end else if (r_enable && !fifo_empty) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive half of the board UART: samples the serial line from the USB-UART bridge, deframes 8N1 bytes and buffers them in a small FIFO.
- Exposes the byte-level handshake the CPU MMIO uses: r_ready, r_enable, r_data_out, r_overflow.
- Runs in the CPU clock domain (10 MHz). The rx pin is asynchronous and is synchronised internally.

Parameters:
- CLK_HZ, 10000000, frequency of clk in Hz.
- BAUD, 115200, line rate.
- FIFO_DEPTH, 16, byte entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  CPU clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  serial line, idle high, asynchronous to clk.
- r_enable  input  1  pop request; head byte consumed at the clk edge when r_ready=1.
- r_ready  output  1  FIFO non-empty.
- r_data_out  output  8  head byte, show-ahead; valid whenever r_ready=1.
- r_overflow  output  1  sticky flag: a received byte was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - all outputs to 0;
  - FIFO empty, pointers 0;
  - FSM to IDLE;
  - synchroniser flops to 1.
- Reset asserted mid-frame or mid-pop aborts immediately; no partial byte is stored.
- CLKS_PER_BIT = CLK_HZ/BAUD, integer division (86 at defaults). HALF = CLKS_PER_BIT/2 (43).
- rx passes through a 2-flop synchroniser, giving rx_s. Edge detection uses rx_s only.
- FSM states:
  - IDLE: wait for rx_s=0. On detection, load bit counter 0, tick counter 0, go to START.
  - START: count to HALF-1. If rx_s=0, go to DATA with tick counter cleared. If rx_s=1 (glitch), return to IDLE.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample:
    - rx_s=1: push the byte (subject to FIFO rules), go to IDLE.
    - rx_s=0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE (prevents a break condition retriggering).
- Latency: a byte becomes visible (r_ready rises) on the clk edge after the STOP sample, which is about 9.5 bit-times after the start edge.
- FIFO:
  - Pointers have log2(FIFO_DEPTH)+1 bits.
  - empty = (wr==rd); full = MSBs differ and the low bits are equal.
  - r_data_out = mem[rd]; it changes only on pop or on a push into an empty FIFO.
- Pop: r_enable=1 with r_ready=1 increments rd. r_enable while empty is ignored and has no side effect.
- Push while full: the byte is dropped and r_overflow is set.
- Simultaneous push and pop while full: the pop frees the slot and the push is accepted; no overflow.
- Simultaneous push and pop while empty: the pop is ignored; the push is stored.
- r_overflow stays set until the first successful pop after it was set. Clearing happens on that pop edge. If a drop and a pop occur in the same cycle, set wins.
- Pointer wrap-around is natural modulo 2*FIFO_DEPTH; no other special handling.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; an extra PARITY state sits between DATA and STOP, one bit-time.
  - Adds output port parity_err (1 bit), a one-cycle pulse when the received parity does not match even parity over the 8 data bits.
  - On parity error the byte is discarded even if the stop bit is good.
- Undefined: 8N1 as above. No parity_err port, no PARITY state.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - a function clks_per_bit(clk_hz, baud);
  - constant DATA_BITS = 8.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides the show-ahead FIFO. It is reused later by the TX path.

Test Plan:
- Reset then idle line: rst low 3 cycles, rx=1 for 2000 cycles -> r_ready=0, r_overflow=0, frame_err never pulses, r_data_out=0.
- Single byte 0xA5 at 115200, correct 8N1 -> r_ready rises within 1 cycle after the STOP sample, r_data_out=0xA5; one r_enable pulse -> r_ready=0.
- Glitch: rx low for 20 cycles (< HALF) -> FSM returns to IDLE, nothing pushed. Then byte 0x3C is received correctly.
- Framing error: byte 0x55 with stop bit 0, followed by 3 bit-times low, then idle -> one frame_err pulse, FIFO stays empty. The next byte 0x12 is received normally.
- Overflow: send 17 bytes 0x00..0x10 without popping -> r_overflow=1 after the 17th. Popping yields 0x00..0x0F in order; r_overflow clears on the first pop.
- Boundary: with FIFO full, assert r_enable in the exact cycle of the push of 0x77 -> no overflow, count stays 16, 0x77 is read last. Async rst mid-DATA -> outputs 0 immediately, no partial byte after release.
